dyn_partition_sched: RTL and testbench

DYN_PARTITION_SCHED -- requirements
Module: dyn_partition_sched

---
 rtl/dps_pkg.sv | 35 +++
 rtl/dps_incr.sv | 11 +
 rtl/dyn_partition_sched.sv | 124 ++++++++++++
 tb/tb_dyn_partition_sched.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dps_pkg.sv
// Shared types and constants for the dynamic-partition scheduler.
package dps_pkg;

  localparam int unsigned DPS_CW_DEFAULT = 3;

  typedef enum logic {
    IDLE = 1'b0,
    STEP = 1'b1
  } state_e;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_e;

  // Johnson phase sequence {p1,p0}: 00 -> 10 -> 11 -> 01 -> 00
  localparam logic [1:0] PH_0 = 2'b00;
  localparam logic [1:0] PH_1 = 2'b10;
  localparam logic [1:0] PH_2 = 2'b11;
  localparam logic [1:0] PH_3 = 2'b01;

  function automatic logic [1:0] phase_next(input logic [1:0] ph);
    case (ph)
      PH_0:    return PH_1;
      PH_1:    return PH_2;
      PH_2:    return PH_3;
      default: return PH_0;
    endcase
  endfunction

  function automatic sel_e preferred_of(input logic [1:0] ph);
    return (ph[1] ^ ph[0]) ? SEL_B : SEL_A;
  endfunction

endpackage

// File: rtl/dps_incr.sv
// Combinational CW-bit modulo incrementer shared by both partition counters.
module dps_incr #(
  parameter int unsigned CW = 3
) (
  input  logic [CW-1:0] i_val,
  output logic [CW-1:0] o_val
);

  assign o_val = i_val + CW'(1'b1);

endmodule

// File: rtl/dyn_partition_sched.sv
// Two-partition step scheduler with Johnson-phase arbitration and a shared incrementer.
// Define DPS_WORK_CONSERVE_EN to let the non-preferred partition use an idle slot.
module dyn_partition_sched
  import dps_pkg::*;
#(
  parameter int unsigned CW = DPS_CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          req_a,
  input  logic          req_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic [CW-1:0] cnt_a,
  output logic [CW-1:0] cnt_b,
  output logic [1:0]    phase,
  output logic          busy,
  output logic          fixpoint
);

  state_e        r_state;
  state_e        w_state_nxt;
  sel_e          r_winner;
  sel_e          w_winner_nxt;
  logic [CW-1:0] r_cnt_a;
  logic [CW-1:0] r_cnt_b;
  logic [1:0]    r_phase;
  logic          r_fixpoint;

  sel_e          w_pref;
  sel_e          w_cand;
  logic          w_pref_req;
  logic          w_eligible;
  logic          w_step_done;
  logic [CW-1:0] w_incr_in;
  logic [CW-1:0] w_incr_out;
  logic [CW-1:0] w_cnt_a_nxt;
  logic [CW-1:0] w_cnt_b_nxt;

  assign w_pref     = preferred_of(r_phase);
  assign w_pref_req = (w_pref == SEL_A) ? req_a : req_b;

`ifdef DPS_WORK_CONSERVE_EN
  sel_e w_other;
  logic w_other_req;
  assign w_other     = (w_pref == SEL_A) ? SEL_B : SEL_A;
  assign w_other_req = (w_pref == SEL_A) ? req_b : req_a;
  assign w_eligible  = w_pref_req | w_other_req;
  assign w_cand      = w_pref_req ? w_pref : w_other;
`else
  assign w_eligible  = w_pref_req;
  assign w_cand      = w_pref;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt  = r_state;
    w_winner_nxt = r_winner;
    case (r_state)
      IDLE: begin
        if (w_eligible && !clear) begin
          w_state_nxt  = STEP;
          w_winner_nxt = w_cand;
        end
      end
      STEP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (clear) w_state_nxt = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_winner <= SEL_A;
    end else begin
      r_state  <= w_state_nxt;
      r_winner <= w_winner_nxt;
    end
  end

  // A clear arriving during STEP aborts the step: no grant and no update.
  assign w_step_done = (r_state == STEP) && !clear;

  assign w_incr_in = (r_winner == SEL_A) ? r_cnt_a : r_cnt_b;

  dps_incr #(.CW(CW)) u_incr (
    .i_val (w_incr_in),
    .o_val (w_incr_out)
  );

  assign w_cnt_a_nxt = (w_step_done && r_winner == SEL_A) ? w_incr_out : r_cnt_a;
  assign w_cnt_b_nxt = (w_step_done && r_winner == SEL_B) ? w_incr_out : r_cnt_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_a    <= '0;
      r_cnt_b    <= '0;
      r_phase    <= PH_0;
      r_fixpoint <= 1'b0;
    end else if (clear) begin
      r_cnt_a    <= '0;
      r_cnt_b    <= '0;
      r_phase    <= PH_0;
      r_fixpoint <= 1'b0;
    end else if (w_step_done) begin
      r_cnt_a    <= w_cnt_a_nxt;
      r_cnt_b    <= w_cnt_b_nxt;
      r_phase    <= phase_next(r_phase);
      r_fixpoint <= r_fixpoint | ((&w_cnt_a_nxt) & (&w_cnt_b_nxt));
    end
  end

  assign gnt_a    = w_step_done && (r_winner == SEL_A);
  assign gnt_b    = w_step_done && (r_winner == SEL_B);
  assign cnt_a    = r_cnt_a;
  assign cnt_b    = r_cnt_b;
  assign phase    = r_phase;
  assign busy     = (r_state == STEP);
  assign fixpoint = r_fixpoint;

endmodule

// File: tb/tb_dyn_partition_sched.sv
// Self-checking bench for dyn_partition_sched: vector table, corner sequences, random vs model.
module tb_dyn_partition_sched;

  localparam int CW = 3;
  localparam int M  = 1 << CW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          req_a = 1'b0;
  logic          req_b = 1'b0;
  logic          gnt_a;
  logic          gnt_b;
  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_b;
  logic [1:0]    phase;
  logic          busy;
  logic          fixpoint;

  dyn_partition_sched #(.CW(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .req_a    (req_a),
    .req_b    (req_b),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .cnt_a    (cnt_a),
    .cnt_b    (cnt_b),
    .phase    (phase),
    .busy     (busy),
    .fixpoint (fixpoint)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: step counter per partition, position in the 4-step phase cycle.
  logic [1:0] ph_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  bit m_step;
  int m_who;
  int m_cnt [2];
  int m_idx;
  bit m_fix;

  function automatic void model_reset();
    m_step = 1'b0;
    m_who  = 0;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    m_idx  = 0;
    m_fix  = 1'b0;
  endfunction

  function automatic void model_edge(input bit c, input bit ra, input bit rb);
    bit r [2];
    int pref;
    r[0] = ra;
    r[1] = rb;
    if (c) begin
      model_reset();
    end else if (m_step) begin
      m_cnt[m_who] = (m_cnt[m_who] + 1) % M;
      m_idx = (m_idx + 1) % 4;
      if (m_cnt[0] == M - 1 && m_cnt[1] == M - 1) m_fix = 1'b1;
      m_step = 1'b0;
    end else begin
      pref = m_idx % 2;  // even positions prefer A, odd prefer B
      if (r[pref]) begin
        m_step = 1'b1;
        m_who  = pref;
      end
`ifdef DPS_WORK_CONSERVE_EN
      else if (r[1-pref]) begin
        m_step = 1'b1;
        m_who  = 1 - pref;
      end
`endif
    end
  endfunction

  task automatic check_model();
    check("gnt_a",    gnt_a,    m_step && m_who == 0 && !clear);
    check("gnt_b",    gnt_b,    m_step && m_who == 1 && !clear);
    check("busy",     busy,     m_step);
    check("cnt_a",    cnt_a,    m_cnt[0]);
    check("cnt_b",    cnt_b,    m_cnt[1]);
    check("phase",    phase,    ph_seq[m_idx]);
    check("fixpoint", fixpoint, m_fix);
  endtask

  task automatic cycle(input bit c, input bit ra, input bit rb);
    clear = c;
    req_a = ra;
    req_b = rb;
    #1;
    check_model();
    @(posedge clk);
    model_edge(c, ra, rb);
    #1;
  endtask

  typedef struct {
    bit         clr;
    bit         ra;
    bit         rb;
    bit         ga;
    bit         gb;
    bit         bz;
    int         ca;
    int         cb;
    logic [1:0] ph;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // single A request, clear, then both held continuously
    tbl[0]  = '{0, 1, 0, 0, 0, 0, 0, 0, 2'b00};
    tbl[1]  = '{0, 0, 0, 1, 0, 1, 0, 0, 2'b00};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 1, 0, 2'b10};
    tbl[3]  = '{1, 0, 0, 0, 0, 0, 1, 0, 2'b10};
    tbl[4]  = '{0, 1, 1, 0, 0, 0, 0, 0, 2'b00};
    tbl[5]  = '{0, 1, 1, 1, 0, 1, 0, 0, 2'b00};
    tbl[6]  = '{0, 1, 1, 0, 0, 0, 1, 0, 2'b10};
    tbl[7]  = '{0, 1, 1, 0, 1, 1, 1, 0, 2'b10};
    tbl[8]  = '{0, 1, 1, 0, 0, 0, 1, 1, 2'b11};
    tbl[9]  = '{0, 1, 1, 1, 0, 1, 1, 1, 2'b11};
    tbl[10] = '{0, 1, 1, 0, 0, 0, 2, 1, 2'b01};
    tbl[11] = '{0, 1, 1, 0, 1, 1, 2, 1, 2'b01};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 2, 2, 2'b00};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 2, 2, 2'b00};

    model_reset();
    #1;
    check("reset_gnt_a", gnt_a, 1'b0);
    check("reset_gnt_b", gnt_b, 1'b0);
    check("reset_busy",  busy,  1'b0);
    check("reset_cnt_a", cnt_a, 0);
    check("reset_cnt_b", cnt_b, 0);
    check("reset_phase", phase, 2'b00);
    check("reset_fix",   fixpoint, 1'b0);
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      clear = tbl[i].clr;
      req_a = tbl[i].ra;
      req_b = tbl[i].rb;
      #1;
      check($sformatf("tbl%0d_gnt_a", i), gnt_a, tbl[i].ga);
      check($sformatf("tbl%0d_gnt_b", i), gnt_b, tbl[i].gb);
      check($sformatf("tbl%0d_busy", i),  busy,  tbl[i].bz);
      check($sformatf("tbl%0d_cnt_a", i), cnt_a, tbl[i].ca);
      check($sformatf("tbl%0d_cnt_b", i), cnt_b, tbl[i].cb);
      check($sformatf("tbl%0d_phase", i), phase, tbl[i].ph);
      check($sformatf("tbl%0d_fix", i),   fixpoint, 1'b0);
      @(posedge clk);
      model_edge(tbl[i].clr, tbl[i].ra, tbl[i].rb);
      #1;
    end

    // phase 10 with only A requesting
    cycle(1, 0, 0);
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    check("nonpref_start_phase", phase, 2'b10);
`ifdef DPS_WORK_CONSERVE_EN
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    check("wc_phase", phase, 2'b11);
    check("wc_cnt_a", cnt_a, 2);
`else
    repeat (6) cycle(0, 1, 0);
    check("strict_phase", phase, 2'b10);
    check("strict_cnt_a", cnt_a, 1);
`endif

    // alternate to 7/7, then one wrapping A step, then clear
    cycle(1, 0, 0);
    repeat (28) cycle(0, 1, 1);
    check("fix_cnt_a", cnt_a, 7);
    check("fix_cnt_b", cnt_b, 7);
    check("fix_set",   fixpoint, 1'b1);
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    check("wrap_cnt_a", cnt_a, 0);
    check("wrap_cnt_b", cnt_b, 7);
    check("fix_sticky", fixpoint, 1'b1);
    cycle(1, 0, 0);
    check("clr_cnt_a", cnt_a, 0);
    check("clr_cnt_b", cnt_b, 0);
    check("clr_phase", phase, 2'b00);
    check("clr_fix",   fixpoint, 1'b0);

    // clear during STEP aborts the step
    repeat (4) cycle(0, 1, 1);
    cycle(0, 1, 0);
    check("pre_abort_busy", busy, 1'b1);
    clear = 1'b1;
    req_a = 1'b0;
    #1;
    check("abort_gnt_a", gnt_a, 1'b0);
    check("abort_gnt_b", gnt_b, 1'b0);
    @(posedge clk);
    model_edge(1, 0, 0);
    #1;
    clear = 1'b0;
    check("abort_cnt_a", cnt_a, 0);
    check("abort_cnt_b", cnt_b, 0);
    check("abort_phase", phase, 2'b00);
    check("abort_busy",  busy,  1'b0);

    // asynchronous reset during STEP
    cycle(0, 1, 1);
    cycle(0, 1, 1);
    cycle(0, 1, 0);
    req_a = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_gnt_a", gnt_a, 1'b0);
    check("arst_busy",  busy,  1'b0);
    check("arst_cnt_a", cnt_a, 0);
    check("arst_phase", phase, 2'b00);
    model_reset();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) cycle(0, 0, 0);

    // randomized traffic against the model
    repeat (400) begin
      cycle($urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
